// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, bus widths,
// the nop word used for rejected requests, and the FIFO entry layout.
package inst_encoder_pkg;

  localparam int TYPE_BUS = 3;
  localparam int REG_BUS  = 32;
  localparam int INST_W   = 32;

  // Instruction formats understood by the encoder; codes 6 and 7 are invalid.
  typedef enum logic [TYPE_BUS-1:0] {
    INST_R = 3'd0,
    INST_I = 3'd1,
    INST_S = 3'd2,
    INST_B = 3'd3,
    INST_U = 3'd4,
    INST_J = 3'd5
  } inst_type_e;

  // addi x0, x0, 0 -- emitted whenever a request cannot be encoded.
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  // One buffered result: encoded word plus its error flag.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic              err;
  } enc_result_t;

  // True when bits [31:lsb] of value are all equal, i.e. the value fits in
  // an (lsb+1)-bit two's-complement field without losing information.
  function automatic logic upper_uniform(input logic [REG_BUS-1:0] value,
                                         input int unsigned lsb);
    logic [REG_BUS-1:0] shifted;
    shifted = $unsigned($signed(value) >>> lsb);
    return (shifted == '0) || (shifted == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Purely combinational field packer: builds the 32-bit word for the selected
// format and flags immediates that do not fit or a format code that is unknown.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [TYPE_BUS-1:0] req_type,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [REG_BUS-1:0]  imm,
  output logic [INST_W-1:0]   inst,
  output logic                err
);

  logic [INST_W-1:0] raw;
  logic              bad;

  // Pack the fields per format and decide whether the immediate is in range.
  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (req_type)
      INST_R: begin
        raw = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      INST_I: begin
        raw = {imm[11:0], rs1, funct3, rd, opcode};
        bad = !upper_uniform(imm, 11);
      end
      INST_S: begin
        raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad = !upper_uniform(imm, 11);
      end
      INST_B: begin
        raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad = !upper_uniform(imm, 12) || imm[0];
      end
      INST_U: begin
        raw = {imm[31:12], rd, opcode};
        bad = (imm[11:0] != 12'd0);
      end
      INST_J: begin
        raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad = !upper_uniform(imm, 20) || imm[0];
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

  assign inst = bad ? INST_NOP : raw;
  assign err  = bad;

endmodule

// File: rtl/inst_encoder.sv
// Valid/ready instruction encoder: requests are packed at accept time and the
// result is queued in a two-entry FIFO whose head drives the outputs.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TYPE_BUS-1:0] in_type,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [REG_BUS-1:0]  in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_W-1:0]   out_inst,
  output logic                out_err,
  output logic [15:0]         enc_count
);

  enc_result_t       fifo_mem [2];
  enc_result_t       head;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] pack_inst;
  logic              pack_err;

  inst_pack u_pack (
    .req_type (in_type),
    .opcode   (in_opcode),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .funct7   (in_funct7),
    .imm      (in_imm),
    .inst     (pack_inst),
    .err      (pack_err)
  );

  assign push      = in_valid && in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign head      = fifo_mem[rd_ptr];

  // Outputs are forced to zero when empty so no stale entry is ever visible.
  assign out_inst = out_valid ? head.inst : '0;
  assign out_err  = out_valid ? head.err  : 1'b0;

  // Occupancy after this cycle's push/pop; a push and pop together cancel.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Control state: occupancy, pointers, registered in_ready and the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      in_ready  <= 1'b0;
      enc_count <= 16'd0;
    end else begin
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        enc_count <= enc_count + 16'd1;
      end
    end
  end

  // Result storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{inst: pack_inst, err: pack_err};
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed format vectors, backpressure,
// mid-operation reset and a randomized run against a queue-based model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;

  int total = 0;
  int bad   = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  // Reference encoder: range rules as plain signed-integer bounds.
  function automatic logic [32:0] model_encode(input int t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    longint s;
    logic   ok;
    logic [31:0] w;
    s  = longint'($signed(imm));
    ok = 1'b0;
    w  = 32'h0;
    case (t)
      0: begin ok = 1'b1; w = {f7, rs2, rs1, f3, rd, op}; end
      1: begin ok = (s >= -2048 && s <= 2047); w = {imm[11:0], rs1, f3, rd, op}; end
      2: begin ok = (s >= -2048 && s <= 2047); w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      3: begin
        ok = (s >= -4096 && s <= 4095 && (s % 2) == 0);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      4: begin ok = ((s % 4096) == 0); w = {imm[31:12], rd, op}; end
      5: begin
        ok = (s >= -1048576 && s <= 1048575 && (s % 2) == 0);
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: ok = 1'b0;
    endcase
    return ok ? {w, 1'b0} : {32'h0000_0013, 1'b1};
  endfunction

  // Immediates biased toward the interesting range boundaries.
  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 5))
      0: v = int'($urandom_range(0, 4095)) - 2048;
      1: v = int'($urandom_range(0, 8191)) - 4096;
      2: v = int'($urandom);
      3: v = int'($urandom) & 32'hFFFF_F000;
      4: v = (int'($urandom_range(0, 2097151)) - 1048576) & ~32'h1;
      default: begin
        case ($urandom_range(0, 5))
          0: v = 2047;
          1: v = -2048;
          2: v = 2048;
          3: v = 4094;
          4: v = -4096;
          default: v = 1048574;
        endcase
      end
    endcase
    return 32'(v);
  endfunction

  task automatic set_req(input int t, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_type   = 3'(t);
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if ({out_inst, out_err} !== 33'h0) begin bad++; $display("[TB] FAIL reset_outputs got=%h/%b want=0/0", out_inst, out_err); end
    total++; if (enc_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_enc_count got=%0d want=0", enc_count); end
    rst = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_before_edge got=%b want=0", in_ready); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_release got=%b want=1", in_ready); end
  endtask

  typedef struct {
    int          t;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  task automatic test_formats();
    vec_t v [11];
    v[0]  = '{1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,           32'h0050_0093, 1'b0};
    v[1]  = '{2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,           32'h0020_A423, 1'b0};
    v[2]  = '{3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,   32'hFE00_0EE3, 1'b0};
    v[3]  = '{4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,   32'h1234_52B7, 1'b0};
    v[4]  = '{5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000,   32'h0000_0013, 1'b1};
    v[5]  = '{3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,           32'h0000_0013, 1'b1};
    v[6]  = '{1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,        32'h0000_0013, 1'b1};
    v[7]  = '{6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,           32'h0000_0013, 1'b1};
    v[8]  = '{0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0};
    v[9]  = '{5, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,        32'h0010_006F, 1'b0};
    v[10] = '{1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,   32'h8000_0093, 1'b0};
    out_ready = 1'b1;
    foreach (v[i]) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_before_vec%0d got=%b want=0", i, out_valid); end
      set_req(v[i].t, v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL vec%0d_in_ready got=%b want=1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL vec%0d_latency out_valid got=%b want=1", i, out_valid); end
      total++; if (out_inst !== v[i].exp_inst || out_err !== v[i].exp_err)
        begin bad++; $display("[TB] FAIL vec%0d_result got=%h/%b want=%h/%b", i, out_inst, out_err, v[i].exp_inst, v[i].exp_err); end
    end
    @(negedge clk);
    total++; if (enc_count !== 16'd11) begin bad++; $display("[TB] FAIL formats_enc_count got=%0d want=11", enc_count); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp [3];
    int sent = 0, got = 0, cyc = 0;
    bit checked = 0;
    bit acc;
    for (int k = 0; k < 3; k++)
      exp[k] = model_encode(1, 7'b0010011, 5'(k + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(k * 16 + 3));
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    while (got < 3 && cyc < 30) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (sent == 2 && !checked) begin
        checked = 1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_in_ready got=%b want=0", in_ready); end
        out_ready = 1'b1;
      end
      if (sent < 3) set_req(1, 7'b0010011, 5'(sent + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(sent * 16 + 3));
      else in_valid = 1'b0;
      if (out_ready && out_valid) begin
        total++; if ({out_inst, out_err} !== exp[got])
          begin bad++; $display("[TB] FAIL order_%0d got=%h/%b want=%h/%b", got, out_inst, out_err, exp[got][32:1], exp[got][0]); end
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    if (got < 3) begin
      bad++; total++;
      $display("[TB] FAIL back_to_back_timeout got=%0d want=3", got);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (enc_count !== 16'd3) begin bad++; $display("[TB] FAIL b2b_enc_count got=%0d want=3", enc_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_req(4, 7'b0110111, 5'(k + 7), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000 * (k + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL buffered_before_reset got=%b want=1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL midrst_in_ready got=%b want=0", in_ready); end
    total++; if (enc_count !== 16'd0) begin bad++; $display("[TB] FAIL midrst_enc_count got=%0d want=0", enc_count); end
    total++; if ({out_inst, out_err} !== 33'h0) begin bad++; $display("[TB] FAIL midrst_outputs got=%h/%b want=0/0", out_inst, out_err); end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stale_after_reset_%0d got=%b want=0", k, out_valid); end
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_midrst got=%b want=1", in_ready); end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [15:0] exp_cnt = 16'd0;
    bit acc, del;
    int t;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if ({out_inst, out_err} !== q[0])
          begin bad++; $display("[TB] FAIL rnd_head cyc=%0d got=%h/%b want=%h/%b", cyc, out_inst, out_err, q[0][32:1], q[0][0]); end
      end
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, q.size() < 2); end
      total++; if (enc_count !== exp_cnt) begin bad++; $display("[TB] FAIL rnd_enc_count cyc=%0d got=%0d want=%0d", cyc, enc_count, exp_cnt); end
      t = int'($urandom_range(0, 7));
      set_req(t, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      acc = in_valid && (q.size() < 2);
      del = out_ready && (q.size() != 0);
      @(posedge clk);
      if (del) begin void'(q.pop_front()); exp_cnt = exp_cnt + 16'd1; end
      if (acc) q.push_back(model_encode(t, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: request carries a field set to encode.
REQ-004 SHALL have port in_ready, output, 1 bit: encoder can accept a request this cycle.
REQ-005 SHALL have port in_type, input, `TYPE_BUS (3 bits): format, R=0, I=1, S=2, B=3, U=4, J=5; values 6 and 7 are invalid.
REQ-006 SHALL have ports in_opcode (7), in_rd (5), in_rs1 (5), in_rs2 (5), in_funct3 (3) and in_funct7 (7), all inputs: raw instruction fields.
REQ-007 SHALL have port in_imm, input, `RegBus (32 bits): sign-extended immediate value, byte offset for B and J.
REQ-008 SHALL have port out_valid, output, 1 bit: out_inst and out_err hold a result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-010 SHALL have port out_inst, output, 32 bits: encoded instruction word.
REQ-011 SHALL have port out_err, output, 1 bit: the request was not encodable.
REQ-012 SHALL have port enc_count, output, 16 bits: number of completed output handshakes.

Function
REQ-013 SHALL accept a request when in_valid and in_ready are both high, and SHALL deliver a result when out_valid and out_ready are both high.
REQ-014 SHALL encode formats as follows:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
REQ-015 SHALL apply these range rules:
- I/S: imm[31:11] all equal.
- B: imm[31:12] all equal and imm[0]=0.
- U: imm[11:0]=0.
- J: imm[31:20] all equal and imm[0]=0.
- R: in_imm ignored.
REQ-016 SHALL, for a range violation or an invalid in_type, output out_inst=32'h0000_0013 (nop) with out_err=1; otherwise out_err=0.
REQ-017 SHALL encode combinationally at accept and store the {out_inst, out_err} result in a 2-entry FIFO; out_valid = FIFO not empty, and outputs show the head entry.
REQ-018 SHALL have a latency of 1 cycle: a request accepted into an empty FIFO in cycle N is valid in cycle N+1.
REQ-019 SHALL drive in_ready from a register, high when the FIFO occupancy is below 2, with no combinational path from out_ready.
REQ-020 SHALL keep occupancy unchanged on a simultaneous push and pop at occupancy 1.
REQ-021 SHALL keep out_valid and the head entry stable while out_valid is high and out_ready is low.
REQ-022 SHALL deliver results in acceptance order.
REQ-023 SHALL ignore out_ready while out_valid is low.
REQ-024 SHALL increment enc_count on every output handshake, wrapping 16'hFFFF to 0.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set: FIFO empty, out_valid=0, in_ready=0, out_inst=0, out_err=0, enc_count=0.
REQ-026 SHALL set in_ready=1 on the first edge after rst falls.
REQ-027 SHALL discard all buffered results when reset is asserted mid-operation; none appear after reset.

Structure
REQ-028 SHALL take the INST_R/I/S/B/U/J codes, `TYPE_BUS, `RegBus and the nop constant from the shared defines.v.
REQ-029 SHALL place encoding and range checking in one combinational sub-module, inst_pack, with the FIFO, handshake and counter in inst_encoder.

Verification
REQ-030 SHALL cover: I, opcode 0010011, rd=1, rs1=0, f3=0, imm=5 -> 0x00500093, err=0, valid next cycle.
REQ-031 SHALL cover: S, opcode 0100011, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423; B, opcode 1100011, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
REQ-032 SHALL cover: U, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7; J with imm=0x00100000 -> 0x00000013, err=1.
REQ-033 SHALL cover: B imm=3, I imm=2048, and in_type=6 -> err=1 and nop for each.
REQ-034 SHALL cover: out_ready low, three requests offered -> in_ready low after the second accept; after out_ready rises, three results in order and enc_count=3.
REQ-035 SHALL cover: rst asserted with 2 entries buffered -> out_valid=0 and enc_count=0 next cycle; no stale output afterwards.
